alu_rs: RTL and testbench



---
 rtl/alu_rs.sv | 197 +++++++++++++++++++
 tb/tb_alu_rs.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched micro-ops until both sources are
// captured (at dispatch or off the CDB), then issues the oldest ready one.

module alu_rs_entry (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic            clr,
  input  logic [7:0]      d_operand,
  input  logic [7:0]      d_flags,
  input  logic [7:0]      d_wbs,
  input  logic [3:0]      d_robid,
  input  logic [1:0]      d_rdy,
  input  logic [1:0][3:0] d_tag,
  input  logic [1:0][7:0] d_val,
  input  logic            cdb_valid,
  input  logic [3:0]      cdb_id,
  input  logic [7:0]      cdb_val,
  output logic            valid,
  output logic            ready,
  output logic [7:0]      operand,
  output logic [7:0]      flags,
  output logic [7:0]      wbs,
  output logic [3:0]      robid,
  output logic [1:0][7:0] val
);
  logic [1:0]      rdy;
  logic [1:0][3:0] tag;

  assign ready = valid & (&rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      operand <= '0;
      flags   <= '0;
      wbs     <= '0;
      robid   <= '0;
      rdy     <= '0;
      tag     <= '0;
      val     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (alloc) begin
      valid   <= 1'b1;
      operand <= d_operand;
      flags   <= d_flags;
      wbs     <= d_wbs;
      robid   <= d_robid;
      rdy     <= d_rdy;
      tag     <= d_tag;
      val     <= d_val;
    end else begin
      if (clr) valid <= 1'b0;
      for (int s = 0; s < 2; s++)
        if (valid && !rdy[s] && cdb_valid && tag[s] == cdb_id) begin
          rdy[s] <= 1'b1;
          val[s] <= cdb_val;
        end
    end
  end
endmodule

module alu_rs #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            disp_valid,
  input  logic [7:0]      disp_operand,
  input  logic [7:0]      disp_flags,
  input  logic [7:0]      disp_wbs,
  input  logic [3:0]      disp_robid,
  input  logic [1:0]      disp_rdy,
  input  logic [1:0][3:0] disp_tag,
  input  logic [1:0][7:0] disp_val,
  output logic            rs_full,
  input  logic            cdb_valid,
  input  logic [3:0]      cdb_id,
  input  logic [7:0]      cdb_val,
  input  logic            fu_busy,
  output logic            issue_transmit,
  output logic [7:0]      issue_operand,
  output logic [1:0][7:0] issue_depvals,
  output logic [7:0]      issue_wbs,
  output logic [7:0]      issue_flags,
  output logic [3:0]      issue_robid
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]            valid, ready, alloc, clr, sel_oh;
  logic [DEPTH-1:0][7:0]       e_operand, e_flags, e_wbs;
  logic [DEPTH-1:0][3:0]       e_robid;
  logic [DEPTH-1:0][1:0][7:0]  e_val;
  logic [DEPTH-1:0][DEPTH-1:0] older;  // older[i][j]: entry i dispatched before j
  logic [IW-1:0]               free_idx, sel_idx;
  logic [1:0]                  new_rdy;
  logic [1:0][7:0]             new_val;
  logic                        disp_fire, issue_fire;

  assign rs_full    = &valid;
  assign disp_fire  = disp_valid && !rs_full && !flush;
  assign issue_fire = (|sel_oh) && !fu_busy && !flush;
  assign alloc      = disp_fire ? (DEPTH'(1) << free_idx) : '0;
  assign clr        = issue_fire ? sel_oh : '0;

  // Immediate form forces src1 ready; a same-cycle CDB hit is captured here.
  always_comb begin
    new_rdy = disp_rdy;
    new_val = disp_val;
    if (disp_flags[2]) new_rdy[1] = 1'b1;
    for (int s = 0; s < 2; s++)
      if (!new_rdy[s] && cdb_valid && disp_tag[s] == cdb_id) begin
        new_rdy[s] = 1'b1;
        new_val[s] = cdb_val;
      end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IW'(i);
  end

  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older[j][i]) sel_oh[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) sel_idx = IW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older <= '0;
    end else if (disp_fire) begin
      for (int j = 0; j < DEPTH; j++)
        if (j != int'(free_idx)) begin
          older[free_idx][j] <= 1'b0;
          older[j][free_idx] <= 1'b1;
        end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_transmit <= 1'b0;
      issue_operand  <= '0;
      issue_depvals  <= '0;
      issue_wbs      <= '0;
      issue_flags    <= '0;
      issue_robid    <= '0;
    end else begin
      issue_transmit <= issue_fire;
      if (issue_fire) begin
        issue_operand <= e_operand[sel_idx];
        issue_depvals <= e_val[sel_idx];
        issue_wbs     <= e_wbs[sel_idx];
        issue_flags   <= e_flags[sel_idx];
        issue_robid   <= e_robid[sel_idx];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    alu_rs_entry u_ent (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .alloc     (alloc[g]),
      .clr       (clr[g]),
      .d_operand (disp_operand),
      .d_flags   (disp_flags),
      .d_wbs     (disp_wbs),
      .d_robid   (disp_robid),
      .d_rdy     (new_rdy),
      .d_tag     (disp_tag),
      .d_val     (new_val),
      .cdb_valid (cdb_valid),
      .cdb_id    (cdb_id),
      .cdb_val   (cdb_val),
      .valid     (valid[g]),
      .ready     (ready[g]),
      .operand   (e_operand[g]),
      .flags     (e_flags[g]),
      .wbs       (e_wbs[g]),
      .robid     (e_robid[g]),
      .val       (e_val[g])
    );
  end
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios with spec constants plus a random run
// checked against an age-ordered queue model of the station.

module tb_alu_rs;
  localparam int DEPTH = 4;

  logic            clk = 1'b0, rst = 1'b1, flush, disp_valid;
  logic [7:0]      disp_operand, disp_flags, disp_wbs;
  logic [3:0]      disp_robid;
  logic [1:0]      disp_rdy;
  logic [1:0][3:0] disp_tag;
  logic [1:0][7:0] disp_val;
  logic            rs_full, cdb_valid, fu_busy, issue_transmit;
  logic [3:0]      cdb_id, issue_robid;
  logic [7:0]      cdb_val, issue_operand, issue_wbs, issue_flags;
  logic [1:0][7:0] issue_depvals;

  alu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
    .disp_operand(disp_operand), .disp_flags(disp_flags), .disp_wbs(disp_wbs),
    .disp_robid(disp_robid), .disp_rdy(disp_rdy), .disp_tag(disp_tag),
    .disp_val(disp_val), .rs_full(rs_full), .cdb_valid(cdb_valid),
    .cdb_id(cdb_id), .cdb_val(cdb_val), .fu_busy(fu_busy),
    .issue_transmit(issue_transmit), .issue_operand(issue_operand),
    .issue_depvals(issue_depvals), .issue_wbs(issue_wbs),
    .issue_flags(issue_flags), .issue_robid(issue_robid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      op, fl, wbs;
    logic [3:0]      rob;
    logic [1:0]      rdy;
    logic [1:0][3:0] tag;
    logic [1:0][7:0] val;
  } ent_t;

  ent_t            q[$];
  logic            exp_tx, exp_full;
  logic [7:0]      exp_op, exp_wbs, exp_fl;
  logic [3:0]      exp_rob;
  logic [1:0][7:0] exp_dv;
  int              nvec = 0, nerr = 0;

  task automatic model_reset();
    q.delete();
    exp_tx = 0; exp_full = 0; exp_op = 0; exp_wbs = 0; exp_fl = 0;
    exp_rob = 0; exp_dv = '0;
  endtask

  // One clock of the model: oldest fully-ready entry issues, then CDB wakes
  // survivors, then the new micro-op (if accepted) joins as youngest.
  task automatic model_step();
    int   idx;
    bit   accept;
    ent_t e;
    idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (idx < 0 && q[i].rdy == 2'b11) idx = i;
    accept = disp_valid && q.size() < DEPTH && !flush;
    exp_tx = 0;
    if (flush) q.delete();
    else begin
      if (idx >= 0 && !fu_busy) begin
        exp_tx = 1; exp_op = q[idx].op; exp_fl = q[idx].fl; exp_wbs = q[idx].wbs;
        exp_rob = q[idx].rob; exp_dv = q[idx].val;
        q.delete(idx);
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        for (int s = 0; s < 2; s++)
          if (!e.rdy[s] && cdb_valid && e.tag[s] == cdb_id) begin
            e.rdy[s] = 1; e.val[s] = cdb_val;
          end
        q[i] = e;
      end
      if (accept) begin
        e.op = disp_operand; e.fl = disp_flags; e.wbs = disp_wbs; e.rob = disp_robid;
        e.rdy = disp_rdy; e.tag = disp_tag; e.val = disp_val;
        if (disp_flags[2]) e.rdy[1] = 1;
        for (int s = 0; s < 2; s++)
          if (!e.rdy[s] && cdb_valid && disp_tag[s] == cdb_id) begin
            e.rdy[s] = 1; e.val[s] = cdb_val;
          end
        q.push_back(e);
      end
    end
    exp_full = (q.size() == DEPTH);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; disp_operand = 0; disp_flags = 0; disp_wbs = 0;
    disp_robid = 0; disp_rdy = 0; disp_tag = '0; disp_val = '0;
    cdb_valid = 0; cdb_id = 0; cdb_val = 0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic [1:0] rdy,
                      input logic [3:0] t0, input logic [3:0] t1,
                      input logic [7:0] v0, input logic [7:0] v1,
                      input logic [7:0] op, input logic [7:0] fl);
    disp_valid = 1; disp_robid = rob; disp_rdy = rdy; disp_tag = {t1, t0};
    disp_val = {v1, v0}; disp_operand = op; disp_flags = fl; disp_wbs = {4'h5, rob};
  endtask

  task automatic test_reset();
    idle(); fu_busy = 0; rst = 1; model_reset();
    #12;
    nvec++;
    if ({issue_transmit, rs_full, issue_operand, issue_depvals, issue_wbs, issue_flags, issue_robid} !== '0) begin
      nerr++;
      $display("FAIL reset_state got tx=%b full=%b op=%h dv=%h rob=%h, want all zero",
               issue_transmit, rs_full, issue_operand, issue_depvals, issue_robid);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_ready();
    disp(4'd2, 2'b11, 0, 0, 8'h05, 8'h03, 8'h01, 8'h00);
    cycle(); idle();
    nvec++;
    if (issue_transmit !== 1'b0) begin nerr++; $display("FAIL ready_edge0 tx got %b want 0", issue_transmit); end
    cycle();
    nvec++;
    if ({issue_transmit, issue_depvals, issue_robid, issue_operand} !== {1'b1, 8'h03, 8'h05, 4'd2, 8'h01}) begin
      nerr++;
      $display("FAIL ready_issue got tx=%b dv=%h rob=%0d op=%h want tx=1 dv=0305 rob=2 op=01",
               issue_transmit, issue_depvals, issue_robid, issue_operand);
    end
    cycle();
    nvec++;
    if (issue_transmit !== 1'b0) begin nerr++; $display("FAIL ready_pulse tx got %b want 0", issue_transmit); end
  endtask

  task automatic test_wakeup();
    disp(4'd3, 2'b01, 0, 4'd7, 8'h11, 8'h00, 8'h02, 8'h00);
    cycle(); idle();
    for (int k = 0; k < 2; k++) cycle();
    cdb_valid = 1; cdb_id = 4'd7; cdb_val = 8'hA5;
    cycle(); idle();
    nvec++;
    if (issue_transmit !== 1'b0) begin nerr++; $display("FAIL wake_capture tx got %b want 0", issue_transmit); end
    cycle();
    nvec++;
    if ({issue_transmit, issue_depvals, issue_robid} !== {1'b1, 8'hA5, 8'h11, 4'd3}) begin
      nerr++;
      $display("FAIL wake_issue got tx=%b dv=%h rob=%0d want tx=1 dv=a511 rob=3",
               issue_transmit, issue_depvals, issue_robid);
    end
  endtask

  task automatic test_bypass_imm();
    disp(4'd4, 2'b00, 4'd3, 4'd9, 8'h00, 8'hEE, 8'h42, 8'h04);
    cdb_valid = 1; cdb_id = 4'd3; cdb_val = 8'h10;
    cycle(); idle();
    nvec++;
    if (issue_transmit !== 1'b0) begin nerr++; $display("FAIL bypass_edge0 tx got %b want 0", issue_transmit); end
    cycle();
    nvec++;
    if ({issue_transmit, issue_depvals[0], issue_robid, issue_operand} !== {1'b1, 8'h10, 4'd4, 8'h42}) begin
      nerr++;
      $display("FAIL bypass_issue got tx=%b dv0=%h rob=%0d op=%h want tx=1 dv0=10 rob=4 op=42",
               issue_transmit, issue_depvals[0], issue_robid, issue_operand);
    end
  endtask

  task automatic test_full();
    fu_busy = 1;
    for (int k = 0; k < DEPTH; k++) begin
      disp(4'(k + 8), 2'b11, 0, 0, 8'(k), 8'(k + 1), 8'h03, 8'h00);
      cycle();
    end
    disp(4'd15, 2'b11, 0, 0, 8'hFF, 8'hFF, 8'h03, 8'h00);
    cycle(); idle();
    nvec++;
    if ({rs_full, issue_transmit} !== 2'b10) begin
      nerr++; $display("FAIL full_hold got full=%b tx=%b want full=1 tx=0", rs_full, issue_transmit);
    end
    fu_busy = 0;
    for (int k = 0; k < DEPTH; k++) begin
      cycle();
      nvec++;
      if ({issue_transmit, issue_robid, rs_full} !== {1'b1, 4'(k + 8), 1'b0}) begin
        nerr++;
        $display("FAIL full_drain%0d got tx=%b rob=%0d full=%b want tx=1 rob=%0d full=0",
                 k, issue_transmit, issue_robid, rs_full, k + 8);
      end
    end
    cycle();
    nvec++;
    if (issue_transmit !== 1'b0) begin nerr++; $display("FAIL full_reject tx got %b want 0", issue_transmit); end
  endtask

  task automatic test_age();
    disp(4'd1, 2'b10, 4'd9, 0, 8'h00, 8'h21, 8'h04, 8'h00); cycle();
    disp(4'd2, 2'b10, 4'd9, 0, 8'h00, 8'h22, 8'h04, 8'h00); cycle();
    idle(); cdb_valid = 1; cdb_id = 4'd9; cdb_val = 8'h77;
    cycle(); idle();
    for (int k = 1; k <= 2; k++) begin
      cycle();
      nvec++;
      if ({issue_transmit, issue_robid, issue_depvals[0]} !== {1'b1, 4'(k), 8'h77}) begin
        nerr++;
        $display("FAIL age_order%0d got tx=%b rob=%0d dv0=%h want tx=1 rob=%0d dv0=77",
                 k, issue_transmit, issue_robid, issue_depvals[0], k);
      end
    end
  endtask

  task automatic test_flush();
    fu_busy = 1;
    for (int k = 0; k < 3; k++) begin disp(4'(k + 1), 2'b11, 0, 0, 8'h1, 8'h2, 8'h0, 8'h0); cycle(); end
    fu_busy = 0; flush = 1; disp(4'd6, 2'b11, 0, 0, 8'h1, 8'h2, 8'h0, 8'h0);
    cycle(); idle();
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({issue_transmit, rs_full} !== 2'b00) begin
        nerr++; $display("FAIL flush_empty%0d got tx=%b full=%b want 0 0", k, issue_transmit, rs_full);
      end
      cycle();
    end
  endtask

  task automatic test_async_reset();
    disp(4'd5, 2'b11, 0, 0, 8'h09, 8'h08, 8'h07, 8'h00); cycle(); idle();
    disp(4'd6, 2'b11, 0, 0, 8'h09, 8'h08, 8'h07, 8'h00); cycle(); idle();
    #2 rst = 1;
    #1;
    nvec++;
    if ({issue_transmit, rs_full} !== 2'b00) begin
      nerr++; $display("FAIL async_rst got tx=%b full=%b want 0 0", issue_transmit, rs_full);
    end
    model_reset();
    @(negedge clk); rst = 0;
    disp(4'd7, 2'b11, 0, 0, 8'h31, 8'h32, 8'h01, 8'h00); cycle(); idle();
    cycle();
    nvec++;
    if ({issue_transmit, issue_robid} !== {1'b1, 4'd7}) begin
      nerr++; $display("FAIL post_rst_issue got tx=%b rob=%0d want tx=1 rob=7", issue_transmit, issue_robid);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      fu_busy = ($urandom_range(9) < 3);
      flush   = ($urandom_range(49) == 0);
      if ($urandom_range(9) < 6)
        disp(4'($urandom), 2'($urandom), 4'($urandom_range(7)), 4'($urandom_range(7)),
             8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(3) == 0) ? 8'h04 : 8'h00);
      if ($urandom_range(1) == 1) begin
        cdb_valid = 1; cdb_id = 4'($urandom_range(7)); cdb_val = 8'($urandom);
      end
      cycle();
      nvec++;
      if ({issue_transmit, rs_full} !== {exp_tx, exp_full}) begin
        nerr++;
        $display("FAIL rand_ctl c=%0d got tx=%b full=%b want tx=%b full=%b",
                 c, issue_transmit, rs_full, exp_tx, exp_full);
      end
      nvec++;
      if ({issue_operand, issue_wbs, issue_flags, issue_robid, issue_depvals[0]} !==
          {exp_op, exp_wbs, exp_fl, exp_rob, exp_dv[0]} ||
          (!exp_fl[2] && issue_depvals[1] !== exp_dv[1])) begin
        nerr++;
        $display("FAIL rand_data c=%0d got op=%h wbs=%h fl=%h rob=%0d dv=%h want op=%h wbs=%h fl=%h rob=%0d dv=%h",
                 c, issue_operand, issue_wbs, issue_flags, issue_robid, issue_depvals,
                 exp_op, exp_wbs, exp_fl, exp_rob, exp_dv);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ready();
    test_wakeup();
    test_bypass_imm();
    test_full();
    test_age();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
